// File: rtl/ram_q_port_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_q_port_if
// Purpose  : Host-side column write, read-request and read-stream bundle.
// Revision : 1.0
// ============================================================================
interface ram_q_port_if #(
    parameter int LANES  = 64,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 19
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_W-1:0]         wr_col;
    logic [LANES*DATA_W-1:0]   wr_data;

    logic                      rd_req_valid;
    logic                      rd_req_ready;
    logic [ADDR_W-1:0]         rd_col_start;
    logic [ADDR_W-1:0]         rd_cnt_m1;

    logic                      rd_valid;
    logic                      rd_ready;
    logic [LANES*DATA_W-1:0]   rd_data;
    logic [ADDR_W-1:0]         rd_col;
    logic                      rd_last;

    modport master (
        output wr_valid, wr_col, wr_data,
        output rd_req_valid, rd_col_start, rd_cnt_m1,
        output rd_ready,
        input  wr_ready, rd_req_ready,
        input  rd_valid, rd_data, rd_col, rd_last
    );

    modport slave (
        input  wr_valid, wr_col, wr_data,
        input  rd_req_valid, rd_col_start, rd_cnt_m1,
        input  rd_ready,
        output wr_ready, rd_req_ready,
        output rd_valid, rd_data, rd_col, rd_last
    );
endinterface
`default_nettype wire

// File: rtl/ram_q_port.sv
`default_nettype none
// ============================================================================
// Module   : ram_q_port
// Purpose  : Master port for the 64-lane Q RAM: column writes, streamed reads.
// Revision : 1.0
// ============================================================================
module ram_q_port #(
    parameter int LANES  = 64,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 19
) (
    input  wire                        clk,
    input  wire                        rst_n,
    ram_q_port_if.slave                host_if,
    output logic [LANES*ADDR_W-1:0]    ram_a_o,
    output logic                       ram_we_o,
    output logic                       ram_oe_o,
    output logic [LANES*DATA_W-1:0]    ram_d_o,
    input  wire  [LANES*DATA_W-1:0]    ram_q_i,
    output logic                       busy_o
);
    localparam int DW = LANES * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   a_q;
    logic                we_q;
    logic                oe_q;
    logic [DW-1:0]       d_q;
    logic [ADDR_W-1:0]   next_col_q;
    logic [ADDR_W-1:0]   rem_q;

    logic                s1_v_q, s1_last_q, s2_v_q, s2_last_q;
    logic [ADDR_W-1:0]   s1_col_q, s2_col_q;

    logic [DW-1:0]       buf_data_q [4];
    logic [ADDR_W-1:0]   buf_col_q  [4];
    logic                buf_last_q [4];
    logic [1:0]          head_q, tail_q;
    logic [2:0]          count_q, count_d;

    logic                idle_empty, wr_acc, rd_acc, pop, push, issue, drain_done;
    logic                out_valid;
    logic [3:0]          committed;

    always_comb begin
        idle_empty = (state_q == IDLE) && (count_q == 3'd0);
        wr_acc     = host_if.wr_valid && idle_empty;
        rd_acc     = host_if.rd_req_valid && idle_empty && !host_if.wr_valid;
        out_valid  = (count_q != 3'd0);
        pop        = out_valid && host_if.rd_ready;
        push       = s2_v_q;
        count_d    = count_q + {2'b00, push} - {2'b00, pop};
        // Entries buffered after this pop plus everything still in the RAM pipe.
        committed  = {1'b0, count_q} - {3'b000, pop} + {3'b000, s1_v_q}
                   + {3'b000, s2_v_q} + 4'd1;
        issue      = (state_q == READ) && (committed <= 4'd4);
        drain_done = !s1_v_q && !s2_v_q && (count_d == 3'd0);
    end

    assign host_if.wr_ready     = idle_empty;
    assign host_if.rd_req_ready = idle_empty && !host_if.wr_valid;
    assign host_if.rd_valid     = out_valid;
    assign host_if.rd_data      = out_valid ? buf_data_q[head_q] : '0;
    assign host_if.rd_col       = out_valid ? buf_col_q[head_q]  : '0;
    assign host_if.rd_last      = out_valid ? buf_last_q[head_q] : 1'b0;

    assign ram_a_o  = {LANES{a_q}};
    assign ram_we_o = we_q;
    assign ram_oe_o = oe_q;
    assign ram_d_o  = d_q;
    assign busy_o   = (state_q != IDLE) || (count_q != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
            d_q        <= '0;
            next_col_q <= '0;
            rem_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_col_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_col_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            we_q      <= wr_acc;
            s1_v_q    <= 1'b0;
            s2_v_q    <= s1_v_q;
            s2_col_q  <= s1_col_q;
            s2_last_q <= s1_last_q;
            if (wr_acc) begin
                a_q <= host_if.wr_col;
                d_q <= host_if.wr_data;
            end

            case (state_q)
                IDLE: begin
                    if (rd_acc) begin
                        a_q        <= host_if.rd_col_start;
                        s1_v_q     <= 1'b1;
                        s1_col_q   <= host_if.rd_col_start;
                        s1_last_q  <= (host_if.rd_cnt_m1 == '0);
                        next_col_q <= host_if.rd_col_start + ADDR_W'(1);
                        rem_q      <= host_if.rd_cnt_m1 - ADDR_W'(1);
                        oe_q       <= 1'b1;
                        state_q    <= (host_if.rd_cnt_m1 == '0) ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        a_q        <= next_col_q;
                        s1_v_q     <= 1'b1;
                        s1_col_q   <= next_col_q;
                        s1_last_q  <= (rem_q == '0);
                        next_col_q <= next_col_q + ADDR_W'(1);
                        rem_q      <= rem_q - ADDR_W'(1);
                        if (rem_q == '0) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (push) begin
                tail_q <= tail_q + 2'd1;
            end
            if (pop) begin
                head_q <= head_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[tail_q] <= ram_q_i;
            buf_col_q[tail_q]  <= s2_col_q;
            buf_last_q[tail_q] <= s2_last_q;
        end
    end
endmodule
`default_nettype wire

// File: doc/ram_q_port.md
# ram_q_port

Master-side port for the 64-lane Q-matrix RAM used by the QR stage of the OMP processor. It turns column-granular write and streaming read requests into the RAM's per-lane address, write-enable, output-enable and data buses. It accounts for the RAM's one-cycle registered-address read latency and returns read data through a backpressured valid/ready stream with a 4-entry output buffer.

## Interface
- LANES, 64, number of RAM lanes; each lane holds one row element of a Q column.
- ADDR_W, 9, per-lane address width (column index).
- DATA_W, 19, per-lane data width.
- CK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- wr_valid / wr_ready  in / out  1 / 1  column write handshake.
- wr_col  in  ADDR_W  destination column.
- wr_data  in  LANES*DATA_W  column data; lane i occupies bits [DATA_W*(i+1)-1 -: DATA_W].
- rd_req_valid / rd_req_ready  in / out  1 / 1  read-burst request handshake.
- rd_col_start  in  ADDR_W  first column of the burst.
- rd_cnt_m1  in  ADDR_W  burst length minus 1; the range 0..511 gives 1..512 columns.
- rd_valid / rd_ready  out / in  1 / 1  read data stream handshake.
- rd_data  out  LANES*DATA_W  column data, same lane packing as wr_data.
- rd_col  out  ADDR_W  column index of the current rd_data beat.
- rd_last  out  1  marks the final beat of the burst.
- busy  out  1  high whenever the state is not IDLE or the buffer is non-empty.
- ram_A  out  LANES*ADDR_W  registered; every lane carries the same column index.
- ram_WE  out  1  registered write enable.
- ram_OE  out  1  registered output enable.
- ram_D  out  LANES*DATA_W  registered write data.
- ram_Q  in  LANES*DATA_W  RAM read data; valid in the cycle after the RAM samples ram_A.

## Operation
- States are IDLE, READ and DRAIN.
- **IDLE**
  - wr_ready=1 and rd_req_ready=1 only while the output buffer is empty.
  - If wr_valid and rd_req_valid are both high, the write wins: wr_ready=1, rd_req_ready=0.
- **Write** (IDLE only, single beat): on accept, at the next edge the port drives ram_A={LANES{wr_col}}, ram_D=wr_data, ram_WE=1 for exactly one cycle. Back-to-back writes run at 1 per cycle.
- **Read accept** goes IDLE→READ.
  - Latch the start column and the remaining count.
  - Set ram_OE=1; it stays 1 through READ and DRAIN and returns to 0 in IDLE.
- **READ**
  - Each issue drives ram_A to the next column and tags a 2-stage in-flight pipe with that column and a last flag.
  - Column index = start + k, modulo 2^ADDR_W, so addresses wrap 511→0.
  - An issue is allowed at an edge only if (buffer occupancy after this edge's pop) + in-flight + 1 ≤ 4. The buffer therefore never overflows.
  - After the last issue, go to DRAIN.
- **DRAIN**: go to IDLE once the in-flight pipe is empty and the buffer is empty.
- **Capture**: ram_Q is pushed into the buffer at the edge where the pipe's stage-2 tag is valid. Capture does not depend on rd_ready.
- **Output**: the head of the buffer drives rd_data, rd_col and rd_last. A pop happens on rd_valid && rd_ready.
- While ram_A is idle it holds its value. Re-latching by the RAM is harmless because capture follows tags only.
- ram_WE=0 throughout READ and DRAIN.

## Timing
- **Reset values**: state IDLE; ram_WE=0, ram_OE=0, ram_A=0, ram_D=0; rd_valid=0, rd_last=0, rd_col=0, rd_data=0; buffer and pipe empty; busy=0; wr_ready=1, rd_req_ready=1.
- **Asserting RST_N low mid-burst**: immediately clears everything above. Partial data is discarded and no beat is emitted after reset.
- **Write latency**:
  - Accept at edge e.
  - RAM bus is valid during cycle e..e+1.
  - Memory is updated at edge e+1.
  - A read of that column accepted at edge e+1 or later returns the new data.
- **Read latency**:
  - Request accepted at e0; first ram_A is driven after e0.
  - RAM latches at e0+1; ram_Q is valid during e0+1..e0+2.
  - Buffer push at e0+2, so rd_valid=1 after e0+2.
- **Throughput**: with rd_ready held high, the port delivers 1 beat per cycle, and an N-column burst ends with rd_last at edge e0+N+1. Under backpressure, issue stalls once 4 entries are committed and resumes on a pop with no bubble beyond one cycle.
- **State timing**: busy deasserts in the cycle after the rd_last pop, which is the same point where state returns to IDLE.

## Test plan
- **Single write then read**:
  - Write col 5 with lane i = i+1, then read start=5, cnt_m1=0.
  - Expect rd_valid 2 cycles after accept, rd_data lanes 1..64, rd_col=5, rd_last=1, then busy=0.
- **Full-rate burst**:
  - Preload cols 0..7, read start=0, cnt_m1=7, rd_ready=1.
  - Expect 8 consecutive beats with rd_col 0..7; rd_last only on col 7; ram_WE stays 0.
- **Wrap-around**: read start=510, cnt_m1=3. Expect rd_col sequence 510, 511, 0, 1.
- **Backpressure**:
  - Read 16 columns with rd_ready toggling 1 of 3 cycles.
  - Expect no dropped or duplicated beat, order preserved, buffer occupancy ≤ 4, in-order data.
- **Simultaneous write and read request in IDLE**:
  - Write is accepted first and rd_req_ready=0 that cycle.
  - The read is accepted next cycle and returns the just-written data.
- **Reset mid-burst**:
  - Assert RST_N low after 3 beats of a 10-column read.
  - Expect all outputs at reset values at once; after release, a new read returns correct data.
